// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_look_ahead_adder_behavioral.sv
// 4-bit carry-look-ahead adder: flat generate/propagate carry equations.
module carry_look_ahead_adder_behavioral (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is expanded directly from Cin so no carry ripples between bits
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign S    = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit CLA,
// with a valid/ready handshake on both the operand and the result side.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STEPS = WIDTH / NIBBLE;
    localparam int unsigned CNT_W = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_next;
    logic              carry;
    logic              a_msb;
    logic              b_msb;
    logic [CNT_W-1:0]  cnt;
    logic [NIBBLE-1:0] nib_s;
    logic              nib_c;

    carry_look_ahead_adder_behavioral u_cla (
        .A   (a_sr[NIBBLE-1:0]),
        .B   (b_sr[NIBBLE-1:0]),
        .Cin (carry),
        .S   (nib_s),
        .Cout(nib_c)
    );

    // New nibble enters at the MSB end; shift form keeps WIDTH=4 legal
    assign acc_next = (acc >> NIBBLE) | (WIDTH'(nib_s) << (WIDTH - NIBBLE));

    // sum/cout/ovf load only on entry to DONE, so they hold between results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry    <= cin;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        cnt      <= '0;
                        state    <= ADD;
                        in_ready <= 1'b0;
                    end
                end
                ADD: begin
                    a_sr  <= a_sr >> NIBBLE;
                    b_sr  <= b_sr >> NIBBLE;
                    carry <= nib_c;
                    acc   <= acc_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= acc_next;
                        cout      <= nib_c;
                        ovf       <= nib_c ^ (a_msb ^ b_msb ^ acc_next[WIDTH-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits; legal values are multiples of 4 and at least 4.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operand set is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts an operand set this cycle.
REQ-006 The block SHALL have ports a and b, input, WIDTH, the unsigned/two's-complement addends.
REQ-007 The block SHALL have port cin, input, 1, the carry-in.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have port sum, output, WIDTH, the result a+b+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1, the carry out of bit WIDTH-1.
REQ-012 The block SHALL have port ovf, output, 1, the signed-overflow flag.

Function
REQ-013 FSM SHALL have states IDLE, ADD, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1: latch a, b, cin, a[WIDTH-1], b[WIDTH-1]; clear nibble counter; go to ADD.
REQ-016 IDLE with in_valid=0: stay IDLE; no register changes.
REQ-017 Each ADD cycle: add the low nibbles of the a/b shift registers plus the carry register through one 4-bit CLA; shift the 4-bit sum in at the MSB end of the sum register; carry register <= CLA carry-out; shift a/b right by 4; increment the counter.
REQ-018 After WIDTH/4 ADD cycles, go to DONE; out_valid SHALL rise exactly WIDTH/4 cycles after the accepting edge (4 for WIDTH=16, 1 for WIDTH=4).
REQ-019 In DONE: cout = final carry; ovf = cout XOR (a_msb XOR b_msb XOR sum[WIDTH-1]); sum/cout/ovf SHALL be stable while out_ready=0.
REQ-020 DONE with out_ready=1: go to IDLE; sum/cout/ovf retain values until the next DONE.
REQ-021 Operands are not accepted in ADD or DONE; in_valid there SHALL have no effect. There is no back-to-back overlap, so throughput is one result per WIDTH/4+2 cycles minimum.
REQ-022 Input changes on a/b/cin after acceptance SHALL not affect the in-flight result.

Reset
REQ-023 rst=1 SHALL immediately force IDLE and set sum=0, cout=0, ovf=0, out_valid=0, counter=0, carry=0, with in_ready=1.
REQ-024 Reset during ADD or DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-025 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-026 Package adder_pkg SHALL hold the state enum (IDLE/ADD/DONE) and constant NIBBLE=4.
REQ-027 The datapath SHALL instantiate exactly one existing 4-bit carry_look_ahead_adder_behavioral (ports A, B, Cin, S, Cout); no other sub-module.
REQ-028 The counter width SHALL be $clog2(WIDTH/4)+1 bits.

Verification
REQ-029 a=0x0003, b=0x0002, cin=0 -> out_valid 4 cycles after accept, sum=0x0005, cout=0, ovf=0.
REQ-030 a=0x00F9, b=0x0007, cin=0 -> sum=0x0100, cout=0 (carry crosses the nibble boundary); a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-032 out_ready held 0 for 3 cycles in DONE -> sum/out_valid stable, in_ready=0, and an in_valid pulse is ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst asserted after 2 ADD cycles -> outputs 0 and in_ready=1 immediately; a new add of 0x1234+0x1111 then yields 0x2345.
REQ-034 WIDTH=4 instance: a=0xF, b=0x1, cin=1 -> one-cycle latency, sum=0x1, cout=1, ovf=0.
